// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a bounded memory
// request/ready handshake, a sticky trap (illegal instruction or memory timeout) and a retired count.
module multicycle_control #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       Op,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_is_instr,
  output logic             memWrite,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             pcSrc,
  output logic             regWrite,
  output logic [1:0]       writeDataSelection,
  output logic             ALUSrc,
  output logic [4:0]       ALUOp,
  output logic [5:0]       EXTOp,
  output logic [2:0]       dataMemoryType,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_LUI = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_XOR = 5'b00111;

  localparam logic [5:0] EXT_S = 6'b000001;
  localparam logic [5:0] EXT_I = 6'b000010;
  localparam logic [5:0] EXT_B = 6'b000100;
  localparam logic [5:0] EXT_J = 6'b001000;
  localparam logic [5:0] EXT_U = 6'b010000;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [3:0] {
    CL_ILL, CL_ALU_R, CL_ALU_I, CL_LUI, CL_LOAD, CL_STORE, CL_BEQ, CL_BNE, CL_JAL
  } class_t;

  state_t         state, state_nxt;
  class_t         cls;
  logic [4:0]     alu_fn;
  logic [2:0]     mem_type;
  logic [WW-1:0]  wait_cnt;
  logic           wait_hit;
  logic           retire;
  logic           trap_set;
  logic [1:0]     cause_nxt;

  // Instruction class and ALU function straight from the IR fields.
  always_comb begin
    cls    = CL_ILL;
    alu_fn = ALU_NOP;
    case (Op)
      OP_R: begin
        if (Funct7 == 7'b0100000 && Funct3 == 3'b000) begin
          cls    = CL_ALU_R;
          alu_fn = ALU_SUB;
        end else if (Funct7 == 7'b0000000) begin
          case (Funct3)
            3'b000:  begin cls = CL_ALU_R; alu_fn = ALU_ADD; end
            3'b111:  begin cls = CL_ALU_R; alu_fn = ALU_AND; end
            3'b110:  begin cls = CL_ALU_R; alu_fn = ALU_OR;  end
            3'b100:  begin cls = CL_ALU_R; alu_fn = ALU_XOR; end
            default: cls = CL_ILL;
          endcase
        end
      end
      OP_I: begin
        case (Funct3)
          3'b000:  begin cls = CL_ALU_I; alu_fn = ALU_ADD; end
          3'b111:  begin cls = CL_ALU_I; alu_fn = ALU_AND; end
          3'b110:  begin cls = CL_ALU_I; alu_fn = ALU_OR;  end
          3'b100:  begin cls = CL_ALU_I; alu_fn = ALU_XOR; end
          default: cls = CL_ILL;
        endcase
      end
      OP_LOAD: begin
        case (Funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: cls = CL_LOAD;
          default:                                cls = CL_ILL;
        endcase
      end
      OP_STORE: begin
        case (Funct3)
          3'b000, 3'b001, 3'b010: cls = CL_STORE;
          default:                cls = CL_ILL;
        endcase
      end
      OP_BR: begin
        case (Funct3)
          3'b000:  cls = CL_BEQ;
          3'b001:  cls = CL_BNE;
          default: cls = CL_ILL;
        endcase
      end
      OP_JAL:  cls = CL_JAL;
      OP_LUI:  cls = CL_LUI;
      default: cls = CL_ILL;
    endcase
  end

  always_comb begin
    case (Funct3)
      3'b000:  mem_type = 3'b011;
      3'b001:  mem_type = 3'b001;
      3'b100:  mem_type = 3'b100;
      3'b101:  mem_type = 3'b010;
      default: mem_type = 3'b000;
    endcase
  end

  assign wait_hit = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    mem_req            = 1'b0;
    mem_is_instr       = 1'b0;
    memWrite           = 1'b0;
    irWrite            = 1'b0;
    pcWrite            = 1'b0;
    pcSrc              = 1'b0;
    regWrite           = 1'b0;
    writeDataSelection = 2'b00;
    ALUSrc             = 1'b0;
    ALUOp              = ALU_NOP;
    EXTOp              = 6'b000000;
    dataMemoryType     = 3'b000;
    retire             = 1'b0;
    trap_set           = 1'b0;
    cause_nxt          = trap_cause;
    case (state)
      FETCH: begin
        mem_req      = 1'b1;
        mem_is_instr = 1'b1;
        // No fetch completes while the block is held in reset.
        if (mem_ready && rstn) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          state_nxt = DECODE;
        end else if (wait_hit) begin
          trap_set  = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
          state_nxt = TRAP;
        end
      end
      DECODE: begin
        if (cls == CL_ILL) begin
          trap_set  = 1'b1;
          cause_nxt = CAUSE_ILLEGAL;
          state_nxt = TRAP;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          CL_ALU_R: begin
            ALUOp     = alu_fn;
            state_nxt = WB;
          end
          CL_ALU_I: begin
            ALUOp     = alu_fn;
            ALUSrc    = 1'b1;
            EXTOp     = EXT_I;
            state_nxt = WB;
          end
          CL_LUI: begin
            ALUOp     = ALU_LUI;
            ALUSrc    = 1'b1;
            EXTOp     = EXT_U;
            state_nxt = WB;
          end
          CL_LOAD, CL_STORE: begin
            ALUOp     = ALU_ADD;
            ALUSrc    = 1'b1;
            EXTOp     = (cls == CL_STORE) ? EXT_S : EXT_I;
            state_nxt = MEM;
          end
          CL_BEQ, CL_BNE: begin
            ALUOp     = ALU_SUB;
            EXTOp     = EXT_B;
            pcWrite   = (cls == CL_BEQ) ? zero : ~zero;
            pcSrc     = pcWrite;
            retire    = 1'b1;
            state_nxt = FETCH;
          end
          CL_JAL: begin
            EXTOp     = EXT_J;
            pcWrite   = 1'b1;
            pcSrc     = 1'b1;
            state_nxt = WB;
          end
          default: begin
            trap_set  = 1'b1;
            cause_nxt = CAUSE_ILLEGAL;
            state_nxt = TRAP;
          end
        endcase
      end
      MEM: begin
        mem_req        = 1'b1;
        memWrite       = (cls == CL_STORE);
        dataMemoryType = mem_type;
        if (mem_ready) begin
          if (cls == CL_STORE) begin
            retire    = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end else if (wait_hit) begin
          trap_set  = 1'b1;
          cause_nxt = CAUSE_TIMEOUT;
          state_nxt = TRAP;
        end
      end
      WB: begin
        regWrite = 1'b1;
        if (cls == CL_LOAD)     writeDataSelection = 2'b01;
        else if (cls == CL_JAL) writeDataSelection = 2'b10;
        retire    = 1'b1;
        state_nxt = FETCH;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt   <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      if (mem_req && !mem_ready) wait_cnt <= wait_cnt + WW'(1);
      else                       wait_cnt <= '0;
      if (retire) instret <= instret + CNT_W'(1);
      if (trap_set) begin
        trap       <= 1'b1;
        trap_cause <= cause_nxt;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instructions are expanded into expected per-cycle output traces.
module tb_multicycle_control;

  localparam int MW = 15;
  localparam int CW = 4;

  localparam logic [2:0] K_ALU = 3'd0, K_LD = 3'd1, K_ST = 3'd2, K_BEQ = 3'd3;
  localparam logic [2:0] K_BNE = 3'd4, K_JAL = 3'd5, K_LUI = 3'd6, K_ILL = 3'd7;
  localparam int NLEGAL = 21;

  typedef struct packed {
    logic          mem_req, mem_is_instr, mem_write, ir_write, pc_write, pc_src, reg_write;
    logic [1:0]    wds;
    logic          alu_src;
    logic [4:0]    alu_op;
    logic [5:0]    ext_op;
    logic [2:0]    dmt;
    logic          trap;
    logic [1:0]    cause;
    logic [CW-1:0] instret;
  } obs_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] kind;
    logic [4:0] alu;
    logic       src;
    logic [5:0] ext;
    logic [2:0] dmt;
  } ins_t;

  typedef struct {
    logic       rstn, rdy, z;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    obs_t       exp;
  } item_t;

  logic clk = 1'b0;
  logic rstn, zero, mem_ready;
  logic [6:0] Op, Funct7;
  logic [2:0] Funct3;
  logic mem_req, mem_is_instr, memWrite, irWrite, pcWrite, pcSrc, regWrite, ALUSrc, trap;
  logic [1:0] writeDataSelection, trap_cause;
  logic [4:0] ALUOp;
  logic [5:0] EXTOp;
  logic [2:0] dataMemoryType;
  logic [CW-1:0] instret;

  multicycle_control #(.MEM_WAIT_MAX(MW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct3(Funct3), .Funct7(Funct7), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_is_instr(mem_is_instr),
    .memWrite(memWrite), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .regWrite(regWrite), .writeDataSelection(writeDataSelection), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .EXTOp(EXTOp), .dataMemoryType(dataMemoryType), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_cnt = 0;
  logic model_trap = 1'b0;
  logic [1:0] model_cause = 2'b00;
  item_t plan[$];
  obs_t exp_q[$];

  function automatic ins_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [2:0] k, input logic [4:0] alu, input logic src,
                              input logic [5:0] ext, input logic [2:0] dmt);
    ins_t e;
    e.op = op; e.f3 = f3; e.f7 = f7; e.kind = k; e.alu = alu; e.src = src; e.ext = ext; e.dmt = dmt;
    return e;
  endfunction

  // Instruction table: encoding and the control values each one must produce.
  function automatic ins_t ins(input int i);
    case (i)
      0:  return mk(7'b0110011, 3'b000, 7'b0000000, K_ALU, 5'b00011, 1'b0, 6'b000000, 3'b000);
      1:  return mk(7'b0110011, 3'b000, 7'b0100000, K_ALU, 5'b00100, 1'b0, 6'b000000, 3'b000);
      2:  return mk(7'b0110011, 3'b111, 7'b0000000, K_ALU, 5'b00101, 1'b0, 6'b000000, 3'b000);
      3:  return mk(7'b0110011, 3'b110, 7'b0000000, K_ALU, 5'b00110, 1'b0, 6'b000000, 3'b000);
      4:  return mk(7'b0110011, 3'b100, 7'b0000000, K_ALU, 5'b00111, 1'b0, 6'b000000, 3'b000);
      5:  return mk(7'b0010011, 3'b000, 7'b0100000, K_ALU, 5'b00011, 1'b1, 6'b000010, 3'b000);
      6:  return mk(7'b0010011, 3'b111, 7'b0000001, K_ALU, 5'b00101, 1'b1, 6'b000010, 3'b000);
      7:  return mk(7'b0010011, 3'b110, 7'b1111111, K_ALU, 5'b00110, 1'b1, 6'b000010, 3'b000);
      8:  return mk(7'b0010011, 3'b100, 7'b0000000, K_ALU, 5'b00111, 1'b1, 6'b000010, 3'b000);
      9:  return mk(7'b0000011, 3'b000, 7'b0010000, K_LD,  5'b00011, 1'b1, 6'b000010, 3'b011);
      10: return mk(7'b0000011, 3'b001, 7'b0000000, K_LD,  5'b00011, 1'b1, 6'b000010, 3'b001);
      11: return mk(7'b0000011, 3'b010, 7'b0000000, K_LD,  5'b00011, 1'b1, 6'b000010, 3'b000);
      12: return mk(7'b0000011, 3'b100, 7'b0000000, K_LD,  5'b00011, 1'b1, 6'b000010, 3'b100);
      13: return mk(7'b0000011, 3'b101, 7'b0000000, K_LD,  5'b00011, 1'b1, 6'b000010, 3'b010);
      14: return mk(7'b0100011, 3'b000, 7'b0000000, K_ST,  5'b00011, 1'b1, 6'b000001, 3'b011);
      15: return mk(7'b0100011, 3'b001, 7'b0000000, K_ST,  5'b00011, 1'b1, 6'b000001, 3'b001);
      16: return mk(7'b0100011, 3'b010, 7'b0000000, K_ST,  5'b00011, 1'b1, 6'b000001, 3'b000);
      17: return mk(7'b1100011, 3'b000, 7'b0000000, K_BEQ, 5'b00100, 1'b0, 6'b000100, 3'b000);
      18: return mk(7'b1100011, 3'b001, 7'b0000000, K_BNE, 5'b00100, 1'b0, 6'b000100, 3'b000);
      19: return mk(7'b1101111, 3'b101, 7'b0011000, K_JAL, 5'b00000, 1'b0, 6'b001000, 3'b000);
      20: return mk(7'b0110111, 3'b011, 7'b0000000, K_LUI, 5'b00001, 1'b1, 6'b010000, 3'b000);
      22: return mk(7'b0110011, 3'b000, 7'b0000001, K_ILL, 5'b00000, 1'b0, 6'b000000, 3'b000);
      23: return mk(7'b0010011, 3'b001, 7'b0000000, K_ILL, 5'b00000, 1'b0, 6'b000000, 3'b000);
      24: return mk(7'b0000011, 3'b011, 7'b0000000, K_ILL, 5'b00000, 1'b0, 6'b000000, 3'b000);
      25: return mk(7'b0100011, 3'b011, 7'b0000000, K_ILL, 5'b00000, 1'b0, 6'b000000, 3'b000);
      26: return mk(7'b1100011, 3'b100, 7'b0000000, K_ILL, 5'b00000, 1'b0, 6'b000000, 3'b000);
      default: return mk(7'b1111111, 3'b000, 7'b0000000, K_ILL, 5'b00000, 1'b0, 6'b000000, 3'b000);
    endcase
  endfunction

  function automatic obs_t base();
    obs_t o = '0;
    o.trap = model_trap;
    o.cause = model_cause;
    o.instret = model_cnt[CW-1:0];
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.mem_req = mem_req; s.mem_is_instr = mem_is_instr; s.mem_write = memWrite;
    s.ir_write = irWrite; s.pc_write = pcWrite; s.pc_src = pcSrc; s.reg_write = regWrite;
    s.wds = writeDataSelection; s.alu_src = ALUSrc; s.alu_op = ALUOp; s.ext_op = EXTOp;
    s.dmt = dataMemoryType; s.trap = trap; s.cause = trap_cause; s.instret = instret;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_item(input ins_t e, input bit garb, input logic rs, input logic rdy,
                          input logic z, input obs_t x);
    item_t it;
    it.rstn = rs; it.rdy = rdy; it.z = z; it.exp = x;
    if (garb) begin
      it.op = 7'($urandom); it.f3 = 3'($urandom); it.f7 = 7'($urandom);
    end else begin
      it.op = e.op; it.f3 = e.f3; it.f7 = e.f7;
    end
    plan.push_back(it);
  endtask

  task automatic retire();
    model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  task automatic trap_tail(input ins_t e);
    for (int i = 0; i < 3; i++) add_item(e, 1, 1'b1, 1'($urandom), 1'($urandom), base());
  endtask

  // A request waits `waits` cycles then completes, unless that reaches the timeout limit.
  task automatic mem_phase(input ins_t e, input bit garb, input obs_t w, input obs_t d,
                           input int waits, output bit ok);
    int n = (waits >= MW) ? MW : waits;
    for (int i = 0; i < n; i++) add_item(e, garb, 1'b1, 1'b0, 1'($urandom), w);
    ok = (waits < MW);
    if (ok) begin
      add_item(e, garb, 1'b1, 1'b1, 1'($urandom), d);
    end else begin
      model_trap = 1'b1;
      model_cause = 2'b10;
      trap_tail(e);
    end
  endtask

  task automatic build(input ins_t e, input int fw, input int mw, input logic z);
    obs_t w, o;
    bit ok;
    bit take;
    w = base(); w.mem_req = 1'b1; w.mem_is_instr = 1'b1;
    o = w; o.ir_write = 1'b1; o.pc_write = 1'b1;
    mem_phase(e, 1, w, o, fw, ok);
    if (!ok) return;
    add_item(e, 0, 1'b1, 1'($urandom), 1'($urandom), base());
    if (e.kind == K_ILL) begin
      model_trap = 1'b1;
      model_cause = 2'b01;
      trap_tail(e);
      return;
    end
    o = base(); o.alu_op = e.alu; o.alu_src = e.src; o.ext_op = e.ext;
    if (e.kind == K_BEQ || e.kind == K_BNE) begin
      take = (e.kind == K_BEQ) ? z : !z;
      o.pc_write = take; o.pc_src = take;
    end
    if (e.kind == K_JAL) begin
      o.pc_write = 1'b1; o.pc_src = 1'b1;
    end
    add_item(e, 0, 1'b1, 1'($urandom), z, o);
    if (e.kind == K_BEQ || e.kind == K_BNE) begin
      retire();
      return;
    end
    if (e.kind == K_LD || e.kind == K_ST) begin
      w = base(); w.mem_req = 1'b1; w.mem_write = (e.kind == K_ST); w.dmt = e.dmt;
      mem_phase(e, 0, w, w, mw, ok);
      if (!ok) return;
      if (e.kind == K_ST) begin
        retire();
        return;
      end
    end
    o = base(); o.reg_write = 1'b1;
    o.wds = (e.kind == K_LD) ? 2'b01 : (e.kind == K_JAL) ? 2'b10 : 2'b00;
    add_item(e, 0, 1'b1, 1'($urandom), 1'($urandom), o);
    retire();
  endtask

  task automatic do_reset(input int n);
    obs_t o;
    model_cnt = 0; model_trap = 1'b0; model_cause = 2'b00;
    o = base(); o.mem_req = 1'b1; o.mem_is_instr = 1'b1;
    for (int i = 0; i < n; i++) add_item(ins(0), 1, 1'b0, 1'($urandom), 1'($urandom), o);
  endtask

  task automatic run_n(input int n);
    item_t it;
    for (int i = 0; i < n && plan.size() > 0; i++) begin
      it = plan.pop_front();
      @(posedge clk); #1;
      rstn = it.rstn; mem_ready = it.rdy; zero = it.z;
      Op = it.op; Funct3 = it.f3; Funct7 = it.f7;
      exp_q.push_back(it.exp);
    end
  endtask

  task automatic run_plan();
    run_n(plan.size());
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 7);
    if (r < 5) return 0;
    if (r < 7) return $urandom_range(1, 3);
    return $urandom_range(10, MW - 1);
  endfunction

  initial begin : compare
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = sample();
        cyc++;
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL trace cycle %0d: got %h, expected %h", cyc, a, e);
        end
      end
    end
  end

  initial begin : stim
    item_t wb;
    int n, kind, idx;
    rstn = 1'b0; mem_ready = 1'b0; zero = 1'b0; Op = '0; Funct3 = '0; Funct7 = '0;

    do_reset(3); run_plan(); #1;
    chk("reset_mem_req", 32'(mem_req), 1);
    chk("reset_is_instr", 32'(mem_is_instr), 1);
    chk("reset_instret", 32'(instret), 0);
    chk("reset_trap", 32'(trap), 0);

    build(ins(0), 0, 0, 1'b0);
    chk("add_trace_len", 32'(plan.size()), 4);
    run_n(3); #1;
    chk("add_exec_aluop", 32'(ALUOp), 32'b00011);
    chk("add_exec_alusrc", 32'(ALUSrc), 0);
    run_plan(); #1;
    chk("add_wb_regwrite", 32'(regWrite), 1);
    chk("add_wb_wds", 32'(writeDataSelection), 0);

    build(ins(12), 0, 3, 1'b0);
    chk("lbu_trace_len", 32'(plan.size()), 8);
    run_n(1); #1;
    chk("add_instret", 32'(instret), 1);
    run_plan(); #1;
    chk("lbu_wb_wds", 32'(writeDataSelection), 32'b01);

    build(ins(17), 0, 0, 1'b1);
    chk("beq_trace_len", 32'(plan.size()), 3);
    run_plan(); #1;
    chk("beq_pcwrite", 32'(pcWrite), 1);
    chk("beq_pcsrc", 32'(pcSrc), 1);
    chk("beq_regwrite", 32'(regWrite), 0);
    chk("beq_instret", 32'(instret), 2);

    build(ins(18), 0, 0, 1'b1);
    chk("bne_trace_len", 32'(plan.size()), 3);
    run_plan(); #1;
    chk("bne_pcwrite", 32'(pcWrite), 0);

    build(ins(15), 0, 0, 1'b0);
    chk("sh_trace_len", 32'(plan.size()), 4);
    run_n(3); #1;
    chk("sh_exec_extop", 32'(EXTOp), 32'b000001);
    run_plan(); #1;
    chk("sh_memwrite", 32'(memWrite), 1);
    chk("sh_dmt", 32'(dataMemoryType), 32'b001);
    build(ins(16), 0, 0, 1'b0);
    run_plan(); #1;
    chk("sw_memwrite", 32'(memWrite), 1);
    chk("sw_dmt", 32'(dataMemoryType), 32'b000);

    // Reset asserted part-way through a write-back cycle.
    build(ins(0), 0, 0, 1'b0);
    wb = plan.pop_back();
    chk("model_wb_regwrite", 32'(wb.exp.reg_write), 1);
    run_plan();
    @(posedge clk); #1;
    Op = wb.op; Funct3 = wb.f3; Funct7 = wb.f7; mem_ready = 1'b0;
    #1; chk("midwb_regwrite_before", 32'(regWrite), 1);
    rstn = 1'b0;
    #1; chk("midwb_regwrite_after", 32'(regWrite), 0);
    chk("midwb_instret", 32'(instret), 0);
    chk("midwb_mem_req", 32'(mem_req), 1);
    do_reset(2); run_plan();

    build(ins(0), 14, 0, 1'b0);
    run_plan(); #1;
    chk("ready_on_last_wait_trap", 32'(trap), 0);
    build(ins(0), MW, 0, 1'b0);
    chk("timeout_trace_len", 32'(plan.size()), MW + 3);
    run_plan(); #1;
    chk("timeout_trap", 32'(trap), 1);
    chk("timeout_cause", 32'(trap_cause), 32'b10);
    chk("timeout_instret", 32'(instret), 1);

    do_reset(2);
    build(ins(5), 0, 0, 1'b0);
    run_plan();
    build(ins(21), 0, 0, 1'b0);
    chk("illegal_trace_len", 32'(plan.size()), 5);
    run_plan(); #1;
    chk("illegal_trap", 32'(trap), 1);
    chk("illegal_cause", 32'(trap_cause), 32'b01);
    chk("illegal_instret", 32'(instret), 1);

    for (int seg = 0; seg < 10; seg++) begin
      do_reset($urandom_range(1, 3));
      n = $urandom_range(10, 30);
      for (int i = 0; i < n; i++) begin
        build(ins($urandom_range(0, NLEGAL - 1)), pick_wait(), pick_wait(), 1'($urandom));
        run_plan();
      end
      kind = $urandom_range(0, 3);
      if (kind == 1) begin
        build(ins($urandom_range(NLEGAL, 26)), pick_wait(), 0, 1'b0);
      end else if (kind == 2) begin
        build(ins($urandom_range(0, NLEGAL - 1)), $urandom_range(MW, MW + 2), 0, 1'b0);
      end else if (kind == 3) begin
        idx = $urandom_range(9, 16);
        build(ins(idx), pick_wait(), $urandom_range(MW, MW + 2), 1'b0);
      end
      run_plan();
    end

    repeat (3) @(posedge clk);
    chk("trace_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle RV32I control decoder. A state machine sequences fetch, decode, execute, memory and write-back, and drives one-cycle control strobes for the tinyCPU datapath. It adds a memory request/ready handshake with a bounded wait, branch/jump/LUI support, a full load/store width set, illegal-instruction trapping and a retired-instruction counter. It sits between the instruction register (source of `Op`, `Funct3`, `Funct7`) and the datapath/memory port.

## Interface
- `MEM_WAIT_MAX`, 15: maximum cycles a request may wait for `mem_ready` before a timeout trap; must be ≥1.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` input 1: the single clock; all state updates on rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `Op` input 7, `Funct3` input 3, `Funct7` input 7: instruction fields from the IR, valid from DECODE onward.
- `zero` input 1: ALU zero flag, valid in EXEC.
- `mem_ready` input 1: memory completes the current request this cycle.
- `mem_req` output 1: memory request, held until `mem_ready`.
- `mem_is_instr` output 1: the request is an instruction fetch.
- `memWrite` output 1: the data request is a store.
- `irWrite` output 1: load the IR.
- `pcWrite` output 1: update the PC.
- `pcSrc` output 1: PC source; 0 = PC+4, 1 = branch/jump target.
- `regWrite` output 1: register file write strobe.
- `writeDataSelection` output 2: write-back source; 00 = ALU, 01 = MEM, 10 = PC+4.
- `ALUSrc` output 1: 1 = ALU B operand is the immediate.
- `ALUOp` output 5: 00000 nop, 00001 lui, 00011 add, 00100 sub, 00101 and, 00110 or, 00111 xor.
- `EXTOp` output 6: immediate format select; [1] I, [0] S, [2] B, [3] J, [4] U, [5] unused (0).
- `dataMemoryType` output 3: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- `trap` output 1: sticky trap flag.
- `trap_cause` output 2: 01 illegal instruction, 10 memory timeout.
- `instret` output CNT_W: count of retired instructions.

## Operation
- **Supported instructions:**
  - R-type: add, sub, and, or, xor.
  - I-type ALU: addi, andi, ori, xori.
  - Loads: lb, lh, lw, lbu, lhu.
  - Stores: sb, sh, sw.
  - Branches: beq, bne.
  - Jump and upper-immediate: jal, lui.
  - Any other `Op`/`Funct3`/`Funct7` combination is illegal.
- **States:** FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH:** `mem_req` = 1 and `mem_is_instr` = 1. On `mem_ready`: `irWrite` = 1, `pcWrite` = 1 with `pcSrc` = 0, then go to DECODE.
- **DECODE:** illegal instruction → TRAP with cause 01; otherwise → EXEC.
- **EXEC:** drives `ALUOp`, `ALUSrc` and `EXTOp` for the decoded class.
  - ALU op or lui → WB.
  - Load or store → MEM, using `ALUOp` = add to form the address.
  - beq/bne: `ALUOp` = sub. If the condition holds (beq: `zero` = 1; bne: `zero` = 0), `pcWrite` = 1 with `pcSrc` = 1. Then retire → FETCH.
  - jal: `pcWrite` = 1 with `pcSrc` = 1 → WB.
- **MEM:** `mem_req` = 1; `memWrite` = 1 for stores; `dataMemoryType` per `Funct3`. On `mem_ready`: a load → WB; a store retires → FETCH.
- **WB:** `regWrite` = 1 for exactly one cycle. `writeDataSelection` = 01 for loads, 10 for jal, 00 otherwise. Retire → FETCH.
- **Control outputs:** Moore/state-qualified decode. Every strobe not named for the current state is 0.
- **Wait counter:** counts cycles with `mem_req` = 1 and `mem_ready` = 0, and clears when a request completes. When it reaches `MEM_WAIT_MAX` → TRAP with cause 10.
- **`instret`:** increments by 1 on each retire and wraps modulo 2^CNT_W.
- **TRAP:** absorbing until reset. `trap` = 1, `trap_cause` holds its value, and all strobes are 0.

## Timing
- **Reset values:** state = FETCH, `instret` = 0, `trap` = 0, `trap_cause` = 00, wait counter = 0.
- **Outputs while in reset:** because state = FETCH, `mem_req` = 1 and `mem_is_instr` = 1; every other strobe is 0.
- **Reset mid-operation:** an asynchronous assert returns the block to FETCH immediately. A pending `memWrite` or `regWrite` drops in the same instant.
- **Ready timing:** `mem_ready` may arrive in the same cycle `mem_req` first rises, which gives zero wait.
- **Latency with zero-wait memory:**
  - R/I ALU, lui, jal: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each wait cycle adds 1 to the latency.
- **Timeout boundary:** with `mem_ready` stuck at 0, the block enters TRAP at the clock edge ending the `MEM_WAIT_MAX`-th wait cycle. `mem_ready` arriving on exactly the cycle the counter would hit the limit counts as success, not a timeout.
- **`instret` update:** registered; the new value is visible the cycle after retirement.

## Test plan
- **Reset/idle:** assert `rstn` = 0 mid-WB → `regWrite` drops immediately, `instret` = 0; after release, `mem_req` = 1 and `mem_is_instr` = 1.
- **add, zero-wait:** `Op` = 0110011, `Funct3` = 000, `Funct7` = 0000000 → sequence FETCH, DECODE, EXEC (`ALUOp` = 00011, `ALUSrc` = 0), WB (`regWrite` = 1, `writeDataSelection` = 00). `instret` goes 0 → 1.
- **lbu with 3 wait cycles in MEM:** `Op` = 0000011, `Funct3` = 100 → `mem_req` held for 4 cycles with `dataMemoryType` = 100, then WB with `writeDataSelection` = 01. Total 8 cycles.
- **Branches:**
  - beq with `zero` = 1 → `pcWrite` = 1 and `pcSrc` = 1 in EXEC, no `regWrite`.
  - bne with `zero` = 1 → `pcWrite` = 0 in EXEC.
  - Both retire in 3 cycles.
- **sh then sw:** `memWrite` = 1 only in MEM, with `dataMemoryType` = 001 then 000. `EXTOp` = 000001 in EXEC.
- **Traps:**
  - `Op` = 1111111 → TRAP with `trap_cause` = 01.
  - Separately, `mem_ready` held at 0 during a fetch with `MEM_WAIT_MAX` = 15 → TRAP after 15 cycles with `trap_cause` = 10.
  - In both cases `instret` is unchanged.
